// File: rtl/sw_debounce_toggle.sv
// sw_debounce_toggle: conditions a raw, bouncing, asynchronous switch pin for the clk domain.
// A two-flop synchroniser feeds a four-state debounce FSM. The FSM accepts a new level only after
// DEBOUNCE_CYCLES consecutive equal synchronised samples.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sw_in        raw switch pin (asynchronous, may bounce)
//   sw_level     debounced level
//   rise_pulse   one-cycle strobe when sw_level goes 0->1
//   fall_pulse   one-cycle strobe when sw_level goes 1->0
//   sw_toggle    flips on every accepted rise
//   press_count  accepted rises, modulo 2^PRESS_W
//
// Timing: the sample that moves the FSM out of LOW/HIGH is the first stable sample.
// The WAIT_* state therefore accepts once it has seen DEBOUNCE_CYCLES-1 more samples.
// A change first sampled on edge 1 shows up on the outputs at edge DEBOUNCE_CYCLES+2.
// When DEBOUNCE_CYCLES is 1, that first sample is enough and the FSM skips the WAIT_* states.
module sw_debounce_toggle #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned PRESS_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_in,
  output logic               sw_level,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic               sw_toggle,
  output logic [PRESS_W-1:0] press_count
);

  localparam int unsigned   LastI   = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [31:0]   LastW   = LastI;
  localparam logic [CNT_W-1:0] CntLast = LastW[CNT_W-1:0];
  localparam bit            Direct  = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {StLow, StWaitH, StHigh, StWaitL} state_e;

  logic               sync1_q, sync2_q;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               toggle_q, toggle_d;
  logic [PRESS_W-1:0] press_q, press_d;
  logic               s;

  assign s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;
    press_d  = press_q;
    unique case (state_q)
      StLow: begin
        if (s) begin
          cnt_d = '0;
          if (Direct) begin
            state_d  = StHigh;
            level_d  = 1'b1;
            rise_d   = 1'b1;
            toggle_d = ~toggle_q;
            press_d  = press_q + PRESS_W'(1);
          end else begin
            state_d = StWaitH;
          end
        end
      end
      StWaitH: begin
        if (!s) begin
          // Bounce: drop back without touching any output.
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d  = StHigh;
          cnt_d    = '0;
          level_d  = 1'b1;
          rise_d   = 1'b1;
          toggle_d = ~toggle_q;
          press_d  = press_q + PRESS_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHigh: begin
        if (!s) begin
          cnt_d = '0;
          if (Direct) begin
            state_d = StLow;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = StWaitL;
          end
        end
      end
      StWaitL: begin
        if (s) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StLow;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLow;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
      press_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      press_q  <= press_d;
    end
  end

  assign sw_level    = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign sw_toggle   = toggle_q;
  assign press_count = press_q;

endmodule

// File: tb/tb_sw_debounce_toggle.sv
// Bench for sw_debounce_toggle with DEBOUNCE_CYCLES=4 and PRESS_W=3.
// The reference model tracks the run length of synchronised samples that differ from the
// accepted level, and accepts the new level when that run reaches DEBOUNCE_CYCLES.
module tb_sw_debounce_toggle;
  localparam int unsigned D  = 4;
  localparam int unsigned PW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_in = 1'b0;
  logic          sw_level, rise_pulse, fall_pulse, sw_toggle;
  logic [PW-1:0] press_count;

  sw_debounce_toggle #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20),
    .PRESS_W        (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .sw_level   (sw_level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .sw_toggle  (sw_toggle),
    .press_count(press_count)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_s1, m_s2, m_level, m_rise, m_fall, m_toggle;
  int m_run, m_press;
  bit saw_pulse;

  typedef struct {
    bit sw;
    bit lvl;
    bit rise;
    bit fall;
    bit tog;
    int press;
  } vec_t;
  vec_t vec[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_rise = 0; m_fall = 0; m_toggle = 0;
    m_run = 0; m_press = 0;
  endtask

  task automatic model_edge(input bit sw);
    bit s;
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = sw;
    m_rise = 0;
    m_fall = 0;
    if (s != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = s;
        m_run = 0;
        if (s) begin
          m_rise = 1;
          m_toggle = ~m_toggle;
          m_press = (m_press + 1) % (1 << PW);
        end else begin
          m_fall = 1;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".level"},  32'(sw_level),    32'(m_level));
    check({tag, ".rise"},   32'(rise_pulse),  32'(m_rise));
    check({tag, ".fall"},   32'(fall_pulse),  32'(m_fall));
    check({tag, ".toggle"}, 32'(sw_toggle),   32'(m_toggle));
    check({tag, ".press"},  32'(press_count), 32'(m_press));
    check({tag, ".both"},   32'(rise_pulse & fall_pulse), 32'd0);
  endtask

  // Drive sw for one clock, advance the model on the edge, compare on the falling edge.
  task automatic step(input bit sw, input bit do_check, input string tag);
    sw_in = sw;
    @(posedge clk);
    model_edge(sw);
    @(negedge clk);
    if (rise_pulse || fall_pulse) saw_pulse = 1;
    if (do_check) check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sw_in = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic press(input int hi, input int lo, input string tag);
    for (int i = 0; i < hi; i++) step(1, 1, tag);
    for (int i = 0; i < lo; i++) step(0, 1, tag);
  endtask

  initial begin
    // Edge k after reset release; sw=1 on edges 1..8, sw=0 from edge 9 on.
    vec[0]  = '{1, 0, 0, 0, 0, 0};
    vec[1]  = '{1, 0, 0, 0, 0, 0};
    vec[2]  = '{1, 0, 0, 0, 0, 0};
    vec[3]  = '{1, 0, 0, 0, 0, 0};
    vec[4]  = '{1, 0, 0, 0, 0, 0};
    vec[5]  = '{1, 1, 1, 0, 1, 1};
    vec[6]  = '{1, 1, 0, 0, 1, 1};
    vec[7]  = '{1, 1, 0, 0, 1, 1};
    vec[8]  = '{0, 1, 0, 0, 1, 1};
    vec[9]  = '{0, 1, 0, 0, 1, 1};
    vec[10] = '{0, 1, 0, 0, 1, 1};
    vec[11] = '{0, 1, 0, 0, 1, 1};
    vec[12] = '{0, 1, 0, 0, 1, 1};
    vec[13] = '{0, 0, 0, 1, 1, 1};
    vec[14] = '{0, 0, 0, 0, 1, 1};
    vec[15] = '{0, 0, 0, 0, 1, 1};

    model_reset();
    saw_pulse = 0;

    // Reset held with sw_in=1 and a running clock
    rst_n = 0;
    sw_in = 1;
    repeat (3) @(negedge clk);
    check("rst.level",  32'(sw_level),    32'd0);
    check("rst.rise",   32'(rise_pulse),  32'd0);
    check("rst.fall",   32'(fall_pulse),  32'd0);
    check("rst.toggle", 32'(sw_toggle),   32'd0);
    check("rst.press",  32'(press_count), 32'd0);
    rst_n = 1;

    // Table: debounce through reset release, then a clean release
    for (int k = 0; k < 16; k++) begin
      step(vec[k].sw, 0, "vec");
      check($sformatf("vec%0d.level", k),  32'(sw_level),    32'(vec[k].lvl));
      check($sformatf("vec%0d.rise", k),   32'(rise_pulse),  32'(vec[k].rise));
      check($sformatf("vec%0d.fall", k),   32'(fall_pulse),  32'(vec[k].fall));
      check($sformatf("vec%0d.toggle", k), 32'(sw_toggle),   32'(vec[k].tog));
      check($sformatf("vec%0d.press", k),  32'(press_count), 32'(vec[k].press));
    end

    // Bounce rejection from LOW
    do_reset();
    saw_pulse = 0;
    repeat (3) step(1, 1, "bounce");
    repeat (2) step(0, 1, "bounce");
    repeat (2) step(1, 1, "bounce");
    repeat (8) step(0, 1, "bounce");
    check("bounce.no_pulse", 32'(saw_pulse),   32'd0);
    check("bounce.press",    32'(press_count), 32'd0);

    // Wrap: 9 presses from reset, press_count 1..7,0,1
    do_reset();
    for (int i = 0; i < 9; i++) begin
      press(7, 7, "wrap");
      check($sformatf("wrap%0d.press", i), 32'(press_count), 32'((i + 1) % 8));
    end
    check("wrap.toggle", 32'(sw_toggle), 32'd1);

    // Async reset mid-WAIT_H: cnt=2 after edge 5 of a new press
    press(8, 8, "pre_async");
    saw_pulse = 0;
    repeat (5) step(1, 1, "async");
    #5;
    rst_n = 0;
    #1;
    model_reset();
    check("async.level",  32'(sw_level),    32'd0);
    check("async.toggle", 32'(sw_toggle),   32'd0);
    check("async.press",  32'(press_count), 32'd0);
    check("async.rise",   32'(rise_pulse),  32'd0);
    @(negedge clk);
    sw_in = 0;
    rst_n = 1;
    repeat (8) step(0, 1, "post_async");
    check("async.no_pulse", 32'(saw_pulse),   32'd0);
    check("async.press2",   32'(press_count), 32'd0);

    // Random hold lengths around the debounce threshold
    for (int r = 0; r < 300; r++) begin
      bit lv;
      int len;
      lv  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int j = 0; j < len; j++) step(lv, 1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
